// File: rtl/mii_net_crc32.sv
// Byte-wide Ethernet CRC-32 (poly 0x04C11DB7, MSB-first register, LSB-first data)
// for MII/RMII: accumulates frame bytes, shifts the FCS out, exposes the raw register.
module mii_net_crc32 #(
   parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  d,
   input  logic        i_d_valid,
   input  logic        i_calc,
   input  logic        i_init,
   output logic [31:0] o_crc_reg,
   output logic [7:0]  o_crc
);

   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic [31:0] crc_reg;
   logic [31:0] crc_next;

   // Eight serial steps unrolled into one XOR network; d[0] enters first.
   function automatic logic [31:0] next_crc8(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[31] ^ b[i];
         r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      return r;
   endfunction

   always_comb crc_next = next_crc8(crc_reg, d);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         crc_reg <= CRC_INIT;
      else if (i_init)
         crc_reg <= CRC_INIT;
      else if (i_d_valid && i_calc)
         crc_reg <= crc_next;
      else if (i_d_valid)
         crc_reg <= {crc_reg[23:0], 8'hFF};
   end

   assign o_crc_reg = crc_reg;

   // Top register byte, bit-reversed and inverted, is the next FCS byte on the wire.
   for (genvar g = 0; g < 8; g++) begin : g_fcs
      assign o_crc[g] = ~crc_reg[31-g];
   end

endmodule

// File: tb/tb_mii_net_crc32.sv
// Randomised bench for mii_net_crc32: stimulus pushes expectations into a scoreboard
// queue, a negedge monitor pops and compares against a reflected software CRC-32 model.
module tb_mii_net_crc32;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [7:0]  d = 8'h00;
   logic        i_d_valid = 1'b0;
   logic        i_calc = 1'b0;
   logic        i_init = 1'b0;
   logic [31:0] o_crc_reg;
   logic [7:0]  o_crc;

   always #5 i_clk = ~i_clk;

   mii_net_crc32 #(.CRC_INIT(32'hFFFFFFFF)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .d(d), .i_d_valid(i_d_valid),
      .i_calc(i_calc), .i_init(i_init), .o_crc_reg(o_crc_reg), .o_crc(o_crc)
   );

   typedef struct {
      int          id;
      logic [31:0] reg_exp;
      bit          chk_reg;
      logic [7:0]  crc_exp;
      bit          chk_crc;
      bit          not_residue;
   } item_t;

   item_t sbq[$];
   item_t mon_it;
   logic  probe = 1'b0;
   int    checks = 0;
   int    failures = 0;

   localparam logic [31:0] RESIDUE = 32'hC704DD7B;

   // Monitor: compares whenever the stimulus side flags a sample point.
   always @(negedge i_clk) begin
      if (probe) begin
         if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow: no expectation queued");
         end else begin
            mon_it = sbq.pop_front();
            if (mon_it.chk_reg) begin
               checks++;
               if (o_crc_reg !== mon_it.reg_exp) begin
                  failures++;
                  $display("FAIL crc_reg id=%0d got=%h exp=%h", mon_it.id, o_crc_reg, mon_it.reg_exp);
               end
            end
            if (mon_it.chk_crc) begin
               checks++;
               if (o_crc !== mon_it.crc_exp) begin
                  failures++;
                  $display("FAIL crc_byte id=%0d got=%h exp=%h", mon_it.id, o_crc, mon_it.crc_exp);
               end
            end
            if (mon_it.not_residue) begin
               checks++;
               if (o_crc_reg === RESIDUE) begin
                  failures++;
                  $display("FAIL flip_differs id=%0d got=%h must differ from %h", mon_it.id, o_crc_reg, RESIDUE);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: textbook reflected CRC-32 (init/xorout all ones).
   function automatic logic [31:0] sw_crc(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   // Final CRC = ~bitrev(reg), so reg = bitrev(~CRC).
   function automatic logic [31:0] model_reg(input logic [7:0] q[$]);
      return bitrev32(~sw_crc(q));
   endfunction

   task automatic step(input bit v, input bit c, input bit ini, input bit rst, input logic [7:0] dd);
      i_d_valid = v; i_calc = c; i_init = ini; i_reset = rst; d = dd;
      @(posedge i_clk); #1;
      i_d_valid = 1'b0; i_init = 1'b0; i_reset = 1'b0;
      i_calc = 1'($urandom); d = 8'($urandom);
   endtask

   task automatic feed(input logic [7:0] q[$], input bit gaps);
      foreach (q[i]) begin
         if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 8'($urandom));
         end
         step(1'b1, 1'b1, 1'b0, 1'b0, q[i]);
      end
   endtask

   task automatic expect_(input int id, input logic [31:0] r, input bit cr,
                          input logic [7:0] c, input bit cc, input bit ne);
      item_t it;
      it.id = id; it.reg_exp = r; it.chk_reg = cr; it.crc_exp = c; it.chk_crc = cc; it.not_residue = ne;
      sbq.push_back(it);
      probe = 1'b1;
      @(negedge i_clk); #1;
      probe = 1'b0;
   endtask

   task automatic do_init();
      step(1'($urandom), 1'($urandom), 1'b1, 1'b0, 8'($urandom));
   endtask

   logic [7:0] chk[$];
   logic [7:0] fcs_b[$];
   logic [7:0] q[$];
   logic [7:0] head[$];
   logic [31:0] fcs;

   initial begin
      chk   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      fcs_b = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      head  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

      // Reset and hold while idle
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_(1, 32'hFFFFFFFF, 1, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 8'($urandom));
      expect_(2, 32'hFFFFFFFF, 1, 8'h00, 1, 0);

      // Check vector, then FCS shift-out
      feed(chk, 0);
      expect_(3, 32'h9B63D02C, 1, 8'h26, 1, 0);
      for (int k = 0; k < 4; k++) begin
         expect_(10 + k, 32'h0, 0, fcs_b[k], 1, 0);
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
      end
      expect_(4, 32'hFFFFFFFF, 1, 8'h00, 1, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
      expect_(5, 32'hFFFFFFFF, 1, 8'h00, 1, 0);

      // Good-frame residue
      do_init();
      q = chk; foreach (fcs_b[i]) q.push_back(fcs_b[i]);
      feed(q, 0);
      expect_(6, RESIDUE, 1, 8'h00, 0, 0);

      // Single-bit corruption never leaves the residue
      for (int t = 0; t < 4; t++) begin
         int idx, bt;
         q = chk; foreach (fcs_b[i]) q.push_back(fcs_b[i]);
         idx = $urandom_range(0, 12); bt = $urandom_range(0, 7);
         q[idx] = q[idx] ^ (8'h01 << bt);
         do_init();
         feed(q, 1);
         expect_(20 + t, model_reg(q), 1, 8'h00, 0, 1);
      end

      // Gaps with random d/calc while invalid
      for (int t = 0; t < 2; t++) begin
         do_init();
         feed(chk, 1);
         expect_(30 + t, 32'h9B63D02C, 1, 8'h00, 0, 0);
      end

      // Abort mid-frame by init, then by reset; the same-cycle byte is discarded
      do_init();
      feed(head, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
      feed(chk, 0);
      expect_(40, 32'h9B63D02C, 1, 8'h00, 0, 0);
      feed(head, 0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
      feed(chk, 0);
      expect_(41, 32'h9B63D02C, 1, 8'h00, 0, 0);

      // 60-byte frames: model FCS, shift-out order, residue after re-feed
      for (int f = 0; f < 3; f++) begin
         q.delete();
         for (int i = 0; i < 60; i++) q.push_back(8'($urandom));
         fcs = sw_crc(q);
         do_init();
         feed(q, f[0]);
         expect_(50 + f, model_reg(q), 1, 8'h00, 0, 0);
         for (int k = 0; k < 4; k++) begin
            expect_(60 + 4 * f + k, 32'h0, 0, fcs[8*k +: 8], 1, 0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
         end
         expect_(80 + f, 32'hFFFFFFFF, 1, 8'h00, 1, 0);
         do_init();
         for (int k = 0; k < 4; k++) q.push_back(fcs[8*k +: 8]);
         feed(q, 0);
         expect_(90 + f, RESIDUE, 1, 8'h00, 0, 0);
      end

      @(negedge i_clk); #1;
      if (sbq.size() != 0) begin
         checks++; failures++;
         $display("FAIL sb_leftover: %0d entries remain, 0 expected", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mii_net_crc32.md
Name: mii_net_crc32

Overview:
Byte-wide Ethernet (IEEE 802.3) CRC-32 generator and checker for the MII/RMII transmit and receive paths. It accumulates the CRC over frame bytes. On transmit it then shifts the FCS out one byte per cycle in wire order. On receive it exposes the raw register, so the caller can compare it against the good-frame residue. One byte is processed per valid cycle.

Parameters:
CRC_INIT, 32'hFFFFFFFF, value the register is loaded with on reset and on i_init.

Ports:
i_clk  input  1  system clock; all state updates on the rising edge.
i_reset  input  1  synchronous, active-high reset.
d  input  8  data byte; d[0] is the first bit on the wire (Ethernet LSB-first).
i_d_valid  input  1  qualifies d; no state change when low (except reset/init).
i_calc  input  1  1: fold d into the CRC; 0: shift the FCS out (d ignored).
i_init  input  1  synchronous re-initialisation of the CRC register.
o_crc_reg  output  32  raw CRC register (non-reflected, MSB-first form).
o_crc  output  8  current FCS byte to transmit.

Behaviour:
- Register crc_reg, 32 bits. Polynomial 0x04C11DB7, non-reflected, computed MSB-first internally.
- Data bits are fed in the order d[0], d[1], ... d[7]. This is equivalent to bit-reversing d and applying the standard MSB-first 8-step update.
- Per bit b: fb = crc_reg[31] ^ b; crc_reg = {crc_reg[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
- The 8-bit step is implemented as one combinational XOR network: single cycle, no pipeline.
- Update priority, evaluated each rising edge:
  1. i_reset=1: crc_reg <= CRC_INIT.
  2. else i_init=1: crc_reg <= CRC_INIT. A byte presented in the same cycle is discarded.
  3. else i_d_valid=1 and i_calc=1: crc_reg <= next_crc8(crc_reg, d).
  4. else i_d_valid=1 and i_calc=0: crc_reg <= {crc_reg[23:0], 8'hFF} (shift out one FCS byte, fill with ones).
  5. else: hold.
- o_crc_reg = crc_reg. This is combinational from the register, so it reflects bytes accepted up to the previous edge.
- o_crc = ~{crc_reg[24],crc_reg[25],...,crc_reg[31]}, i.e. the bitwise inverse of bit-reversed crc_reg[31:24]. It is combinational and valid in every cycle.
- Transmit FCS sequence: after the last data byte, hold i_calc=0 and i_d_valid=1 for 4 cycles. The bytes sampled from o_crc on those 4 cycles are the FCS in wire order.
- A 5th or later shift gives o_crc = 8'h00, because the register is filled with 1s.
- Final Ethernet CRC value = ~bitreverse32(crc_reg).
- Receive check: feed all frame bytes including the 4 FCS bytes with i_calc=1. A good frame leaves o_crc_reg == 32'hC704DD7B.
- Reset values: crc_reg = 32'hFFFFFFFF, so o_crc_reg = FFFFFFFF and o_crc = 8'h00.
- Reset or init asserted mid-frame aborts the accumulation. Inputs need no settling time afterwards: the next valid byte is processed on the following edge.
- i_d_valid=0 freezes the state regardless of i_calc. Gaps between bytes are allowed.
- No X-propagation on d is allowed to reach crc_reg unless i_d_valid=1.

Test Plan:
- Reset: assert i_reset for one edge -> o_crc_reg=32'hFFFFFFFF, o_crc=8'h00; values hold while i_d_valid=0.
- Check vector: feed ASCII "123456789" (31..39) with i_calc=1 -> o_crc_reg=32'h9B63D02C.
  - Then shift 4 cycles with i_calc=0 -> o_crc sequence 26, 39, F4, CB (CRC 0xCBF43926).
  - A 5th shift -> o_crc=00, o_crc_reg=FFFFFFFF.
- Residue: feed "123456789" followed by 26 39 F4 CB with i_calc=1 -> o_crc_reg=32'hC704DD7B. Flip any single bit in any byte -> value differs.
- Gaps: repeat the check vector with i_d_valid deasserted for random cycles between bytes (d randomised during gaps) -> identical result 9B63D02C.
- Init/reset mid-frame: feed "12345", pulse i_init (with i_d_valid=1 and d=8'hAA the same cycle), then feed "123456789" -> 9B63D02C. Repeat using i_reset instead -> same result.
- 60-byte minimum frame: feed 60 random bytes, shift out the FCS, then re-feed frame plus FCS after i_init -> residue C704DD7B. The FCS bytes must match a software CRC-32 reference model.
